// File: rtl/fx_dot_mac.sv
`default_nettype none
// ============================================================================
// fx_dot_mac : multi-lane fixed-point dot-product MAC with round and saturate.
// Define FX_DOT_RNE_EN for round-half-to-even.                Rev 1.0
// ============================================================================
module fx_dot_mac #(
   parameter int WIDTH    = 8,
   parameter int FRACTION = 4,
   parameter int LANES    = 4,
   parameter int K        = 16
) (
   input  logic                     clk_i,
   input  logic                     rstn,
   input  logic                     clr_i,
   input  logic                     vld_i,
   output logic                     rdy_o,
   input  logic [LANES*WIDTH-1:0]   win,
   input  logic [LANES*WIDTH-1:0]   din,
   output logic [WIDTH-1:0]         acc_o,
   output logic                     sat_o,
   output logic                     vld_o,
   input  logic                     rdy_i
);

   localparam int PW = 2 * WIDTH;
   localparam int SW = PW + $clog2(LANES);
   localparam int AW = SW + $clog2(K) + 1;
   localparam int RW = AW + 1;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   localparam logic [CW-1:0]          C_KM1  = CW'(K - 1);
   localparam logic [FRACTION-1:0]    C_HALF = {1'b1, {(FRACTION-1){1'b0}}};
   localparam logic signed [RW-1:0]   C_RMAX = {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [RW-1:0]   C_RMIN = {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0]       C_OMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0]       C_OMIN = {1'b1, {(WIDTH-1){1'b0}}};

   // S_INIT keeps rdy_o low until the first edge after reset release
   localparam logic [1:0] S_INIT  = 2'd0;
   localparam logic [1:0] S_ACC   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   logic [1:0]              state_q, state_d;
   logic [CW-1:0]           cnt_q;
   logic                    w_take, w_last, w_done;

   logic signed [PW-1:0]    w_prod [LANES];
   logic signed [PW-1:0]    prod_q [LANES];
   logic                    p1_vld_q, p1_last_q;
   logic signed [SW-1:0]    w_sum;
   logic signed [SW-1:0]    sum_q;
   logic                    p2_vld_q, p2_last_q;
   logic signed [AW-1:0]    acc_q;
   logic                    p3_last_q;

   logic signed [AW-1:0]    w_trunc;
   logic [FRACTION-1:0]     w_rem;
   logic                    w_inc;
   logic signed [RW-1:0]    w_r;
   logic [WIDTH-1:0]        w_res;
   logic                    w_sat;
   logic [WIDTH-1:0]        res_q;
   logic                    sat_q;

   assign w_take = vld_i & rdy_o;
   assign w_last = w_take & (cnt_q == C_KM1);
   assign w_done = vld_o & rdy_i;

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) state_q <= S_INIT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clr_i) begin
         state_d = S_ACC;
      end else begin
         case (state_q)
            S_INIT:  state_d = S_ACC;
            S_ACC:   if (w_last)    state_d = S_DRAIN;
            S_DRAIN: if (p3_last_q) state_d = S_OUT;
            S_OUT:   if (rdy_i)     state_d = S_ACC;
            default: state_d = S_ACC;
         endcase
      end
   end

   always_comb begin
      rdy_o = (state_q == S_ACC);
      vld_o = (state_q == S_OUT);
   end

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn)                 cnt_q <= '0;
      else if (clr_i || w_done)  cnt_q <= '0;
      else if (w_take)           cnt_q <= w_last ? '0 : cnt_q + CW'(1);
   end

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         logic signed [WIDTH-1:0] w_wt, w_dt;
         assign w_wt      = win[i*WIDTH +: WIDTH];
         assign w_dt      = din[i*WIDTH +: WIDTH];
         assign w_prod[i] = PW'(w_wt) * PW'(w_dt);
      end
   endgenerate

   // P1: per-lane products; clr_i squashes a beat offered on the same edge
   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
         p1_vld_q  <= 1'b0;
         p1_last_q <= 1'b0;
      end else begin
         p1_vld_q  <= w_take & ~clr_i;
         p1_last_q <= w_last & ~clr_i;
         if (w_take) begin
            for (int i = 0; i < LANES; i++) prod_q[i] <= w_prod[i];
         end
      end
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < LANES; i++) w_sum = w_sum + SW'(prod_q[i]);
   end

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         sum_q     <= '0;
         p2_vld_q  <= 1'b0;
         p2_last_q <= 1'b0;
      end else begin
         p2_vld_q  <= p1_vld_q & ~clr_i;
         p2_last_q <= p1_last_q & ~clr_i;
         if (p1_vld_q) sum_q <= w_sum;
      end
   end

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         acc_q     <= '0;
         p3_last_q <= 1'b0;
      end else begin
         p3_last_q <= p2_last_q & ~clr_i;
         if (clr_i || w_done) acc_q <= '0;
         else if (p2_vld_q)   acc_q <= acc_q + AW'(sum_q);
      end
   end

   assign w_trunc = acc_q >>> FRACTION;
   assign w_rem   = acc_q[FRACTION-1:0];
`ifdef FX_DOT_RNE_EN
   assign w_inc = (w_rem > C_HALF) | ((w_rem == C_HALF) & w_trunc[0]);
`else
   assign w_inc = w_rem[FRACTION-1];
`endif
   assign w_r = RW'(w_trunc) + {{(RW-1){1'b0}}, w_inc};

   always_comb begin
      w_res = w_r[WIDTH-1:0];
      w_sat = 1'b0;
      if (w_r > C_RMAX) begin
         w_res = C_OMAX;
         w_sat = 1'b1;
      end else if (w_r < C_RMIN) begin
         w_res = C_OMIN;
         w_sat = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         res_q <= '0;
         sat_q <= 1'b0;
      end else if (clr_i) begin
         res_q <= '0;
         sat_q <= 1'b0;
      end else if (p3_last_q) begin
         res_q <= w_res;
         sat_q <= w_sat;
      end
   end

   assign acc_o = res_q;
   assign sat_o = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_fx_dot_mac.sv
`default_nettype none
// tb_fx_dot_mac : scoreboard bench driving a K=2 and a K=1 instance of fx_dot_mac.
module tb_fx_dot_mac;
   typedef struct { int acc; int sat; } res_t;

`ifdef FX_DOT_RNE_EN
   localparam int TIE_P8  = 0;
   localparam int TIE_M24 = -2;
`else
   localparam int TIE_P8  = 1;
   localparam int TIE_M24 = -1;
`endif

   logic clk_i = 1'b0, rstn = 1'b0, clr_i = 1'b0;

   logic               vld2 = 1'b0, rdy_i2 = 1'b1;
   logic [31:0]        win2 = '0, din2 = '0;
   logic               rdy_o2, sat_o2, vld_o2;
   logic signed [7:0]  acc_o2;

   logic               vld1 = 1'b0, rdy_i1 = 1'b1;
   logic [31:0]        win1 = '0, din1 = '0;
   logic               rdy_o1, sat_o1, vld_o1;
   logic signed [7:0]  acc_o1;

   res_t q2[$];
   res_t q1[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk_i = ~clk_i;

   fx_dot_mac #(.WIDTH(8), .FRACTION(4), .LANES(4), .K(2)) u_dut2 (
      .clk_i(clk_i), .rstn(rstn), .clr_i(clr_i), .vld_i(vld2), .rdy_o(rdy_o2),
      .win(win2), .din(din2), .acc_o(acc_o2), .sat_o(sat_o2), .vld_o(vld_o2), .rdy_i(rdy_i2));

   fx_dot_mac #(.WIDTH(8), .FRACTION(4), .LANES(4), .K(1)) u_dut1 (
      .clk_i(clk_i), .rstn(rstn), .clr_i(clr_i), .vld_i(vld1), .rdy_o(rdy_o1),
      .win(win1), .din(din1), .acc_o(acc_o1), .sat_o(sat_o1), .vld_o(vld_o1), .rdy_i(rdy_i1));

   task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk_i) begin : mon2
      res_t e;
      if (vld_o2 && rdy_i2) begin
         if (q2.size() == 0) begin
            check("k2 result with no expectation", q2.size(), 1);
         end else begin
            e = q2.pop_front();
            check("k2 acc_o", acc_o2, e.acc);
            check("k2 sat_o", sat_o2, e.sat);
         end
      end
   end

   always @(negedge clk_i) begin : mon1
      res_t e;
      if (vld_o1 && rdy_i1) begin
         if (q1.size() == 0) begin
            check("k1 result with no expectation", q1.size(), 1);
         end else begin
            e = q1.pop_front();
            check("k1 acc_o", acc_o1, e.acc);
            check("k1 sat_o", sat_o1, e.sat);
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic beat2(input logic [7:0] w, input logic [7:0] d);
      for (int i = 0; i < 40 && !rdy_o2; i++) tick();
      if (!rdy_o2) check("k2 rdy_o timeout", rdy_o2, 1);
      vld2 = 1'b1;
      win2 = {4{w}};
      din2 = {4{d}};
      tick();
      vld2 = 1'b0;
   endtask

   task automatic vec2(input logic [7:0] w, input logic [7:0] d, input int ea, input int es);
      q2.push_back('{ea, es});
      beat2(w, d);
      beat2(w, d);
   endtask

   task automatic wait_vld2();
      for (int i = 0; i < 40 && !vld_o2; i++) tick();
      if (!vld_o2) check("k2 vld_o timeout", vld_o2, 1);
   endtask

   task automatic drain2();
      for (int i = 0; i < 60 && q2.size() != 0; i++) tick();
      if (q2.size() != 0) begin
         check("k2 drain timeout", q2.size(), 0);
         q2.delete();
      end
   endtask

   task automatic beat1(input logic [31:0] w, input logic [31:0] d, input int ea, input int es);
      for (int i = 0; i < 40 && !rdy_o1; i++) tick();
      if (!rdy_o1) check("k1 rdy_o timeout", rdy_o1, 1);
      q1.push_back('{ea, es});
      vld1 = 1'b1;
      win1 = w;
      din1 = d;
      tick();
      vld1 = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin : main
      int exp_v[5];
      int exp_r[5];
      exp_v = '{0, 0, 0, 1, 0};
      exp_r = '{0, 0, 0, 0, 1};

      // reset
      repeat (3) @(posedge clk_i);
      #1;
      check("reset rdy_o", rdy_o2, 0);
      check("reset vld_o", vld_o2, 0);
      check("reset acc_o", acc_o2, 0);
      check("reset sat_o", sat_o2, 0);
      rstn = 1'b1;
      check("rdy_o before first edge", rdy_o2, 0);
      tick();
      check("rdy_o after first edge", rdy_o2, 1);

      // basic vector with latency profile
      vec2(8'd16, 8'd8, 64, 0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         check("latency vld_o", vld_o2, exp_v[i]);
         check("latency rdy_o", rdy_o2, exp_r[i]);
      end
      drain2();

      vec2(8'd16,  8'd16, 127, 1);
      vec2(8'hE0,  8'd16, -128, 1);
      vec2(8'hF0,  8'd16, -128, 0);
      q2.push_back('{16, 0});
      beat2(8'd16, 8'd8);
      beat2(8'hF0, 8'd4);
      drain2();

      // bubbles 1,0,0,1
      q2.push_back('{64, 0});
      beat2(8'd16, 8'd8);
      check("bubble rdy_o", rdy_o2, 1);
      tick();
      check("bubble rdy_o", rdy_o2, 1);
      tick();
      check("bubble rdy_o", rdy_o2, 1);
      beat2(8'd16, 8'd8);
      for (int i = 0; i < 4; i++) begin
         check("drain/out rdy_o", rdy_o2, 0);
         tick();
      end
      drain2();

      // backpressure in OUT
      rdy_i2 = 1'b0;
      vec2(8'd16, 8'd16, 127, 1);
      wait_vld2();
      for (int i = 0; i < 5; i++) begin
         check("hold vld_o", vld_o2, 1);
         check("hold acc_o", acc_o2, 127);
         check("hold sat_o", sat_o2, 1);
         check("hold rdy_o", rdy_o2, 0);
         tick();
      end
      rdy_i2 = 1'b1;
      tick();
      check("consumed vld_o", vld_o2, 0);
      vec2(8'd16, 8'd8, 64, 0);
      drain2();

      // clr after beat 1
      beat2(8'd16, 8'd16);
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      check("clr mid vld_o", vld_o2, 0);
      check("clr mid rdy_o", rdy_o2, 1);
      vec2(8'hF0, 8'd16, -128, 0);
      drain2();

      // clr during OUT
      rdy_i2 = 1'b0;
      beat2(8'd16, 8'd16);
      beat2(8'd16, 8'd16);
      wait_vld2();
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      check("clr out vld_o", vld_o2, 0);
      check("clr out rdy_o", rdy_o2, 1);
      check("clr out sat_o", sat_o2, 0);
      rdy_i2 = 1'b1;
      vec2(8'd16, 8'd8, 64, 0);
      drain2();

      // async reset mid-vector
      beat2(8'd16, 8'd16);
      #2;
      rstn = 1'b0;
      #1;
      check("async rst rdy_o", rdy_o2, 0);
      check("async rst vld_o", vld_o2, 0);
      check("async rst acc_o", acc_o2, 0);
      check("async rst sat_o", sat_o2, 0);
      tick();
      rstn = 1'b1;
      check("post rst rdy_o", rdy_o2, 0);
      tick();
      check("post rst rdy_o edge", rdy_o2, 1);
      vec2(8'd16, 8'd8, 64, 0);
      drain2();

      // K=1 instance: rounding ties, lane packing, extreme product
      beat1(32'h0000_0001, 32'h0000_0008, TIE_P8, 0);
      beat1(32'h0000_0001, 32'h0000_0018, 2, 0);
      beat1(32'h0000_0001, 32'h0000_00E8, TIE_M24, 0);
      beat1(32'h0403_0201, 32'h0505_0505, 3, 0);
      beat1(32'h8000_0000, 32'h8000_0000, 127, 1);
      for (int i = 0; i < 60 && q1.size() != 0; i++) tick();

      check("k2 scoreboard empty", q2.size(), 0);
      check("k1 scoreboard empty", q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fx_dot_mac.md
# fx_dot_mac

Multi-lane fixed-point dot-product MAC. Each accepted beat carries LANES weight/data pairs; their products are summed by a registered adder tree and accumulated over K beats. The K-beat result is then rounded, saturated to WIDTH bits with FRACTION fractional bits, and presented on a valid/ready output. It replaces the single-lane MAC in the compute datapath, adding per-lane parallelism, input/output handshakes, abort and a saturation flag.

## Interface
- WIDTH, 8, bit width of each operand and of the result (signed, two's complement)
- FRACTION, 4, fractional bits of operands and result; legal range 2 ≤ FRACTION < WIDTH
- LANES, 4, products per beat; must be ≥ 1
- K, 16, beats accumulated per result; must be ≥ 1
- clk_i  in  1  clock; all state changes on the rising edge
- rstn  in  1  reset, asynchronous assert, active-low, clears all state
- clr_i  in  1  synchronous abort; discards the partial vector and any pending result
- vld_i  in  1  input beat valid
- rdy_o  out  1  input ready; a beat is accepted on an edge where vld_i & rdy_o
- win  in  LANES*WIDTH  packed signed weights; lane i is bits [i*WIDTH +: WIDTH]
- din  in  LANES*WIDTH  packed signed data, same packing as win
- acc_o  out  WIDTH  rounded, saturated result
- sat_o  out  1  result on acc_o was clipped; qualified by vld_o
- vld_o  out  1  result valid; held until accepted
- rdy_i  in  1  downstream ready; the result is consumed on an edge where vld_o & rdy_i

## Operation
- Widths: product PW = 2*WIDTH. Lane sum SW = PW + clog2(LANES). Accumulator AW = SW + clog2(K) + 1. All arithmetic is signed and sign-extended, with no intermediate overflow.
- Pipeline: P1 registers LANES products of the accepted beat. P2 registers the lane sum. P3 adds the lane sum into the accumulator, which starts from 0 on beat 1 of each vector. P4 registers rounding and saturation into acc_o/sat_o.
- FSM states:
  - ACC: rdy_o=1; beat counter increments per accepted beat. Acceptance of beat K → DRAIN.
  - DRAIN: rdy_o=0; waits until the K-th beat's lane sum has been accumulated and P4 has loaded → OUT.
  - OUT: rdy_o=0, vld_o=1; on rdy_i → ACC, with counter and accumulator cleared.
- vld_i low in ACC inserts a bubble. Bubbles do not advance the counter or alter the accumulator.
- Rounding: round half up. r = (acc + 2^(FRACTION-1)) >>> FRACTION (arithmetic shift).
- Saturation: if r > 2^(WIDTH-1)-1, acc_o = 2^(WIDTH-1)-1 and sat_o=1. If r < -2^(WIDTH-1), acc_o = -2^(WIDTH-1) and sat_o=1. Otherwise acc_o = r[WIDTH-1:0] and sat_o=0.
- clr_i (any state) → ACC on the next edge. Counter, accumulator, pipeline valids, vld_o and sat_o are cleared. clr_i has priority over a simultaneous beat acceptance or result consumption.
- K=1: every accepted beat produces a result.

## Timing
- Reset values: rdy_o=0 while rstn=0, then 1 from the first edge after release (state ACC). acc_o=0, sat_o=0, vld_o=0. All internal registers are 0.
- Latency: the K-th beat is accepted at edge E0. vld_o rises after edge E0+3, i.e. the cycle following E0+3.
- Throughput: one result per K+3+w cycles, where w is the number of cycles vld_o waits for rdy_i. With rdy_i held high, w=1.
- acc_o and sat_o are stable throughout OUT. vld_o deasserts on the edge after the consuming edge, unless that edge is also... no: vld_o deasserts on the consuming edge itself (no overlap with the next vector).
- rdy_o returns to 1 in the cycle after consumption.
- rstn asserted mid-vector aborts it immediately (asynchronous). No partial result is ever emitted.

## Configuration
- FX_DOT_RNE_EN defined: rounding is round-half-to-even. A discarded remainder of exactly 2^(FRACTION-1) rounds toward the even r. Other remainders round to nearest.
- FX_DOT_RNE_EN undefined: round half up, as in Operation.
- Saturation, widths and timing are identical in both builds.

## Test plan
- WIDTH=8, FRACTION=4, LANES=4, K=2; all win=16, din=8, two beats back-to-back, rdy_i=1 → acc_o=64, sat_o=0. vld_o rises after E0+3 and stays high for 1 cycle.
- Same config; all win=16, din=16 → acc_o=127, sat_o=1. All win=-32, din=16 → acc_o=-128, sat_o=1. All win=-16, din=16 → acc_o=-128, sat_o=0.
- K=1; lane0 win=1, din=8, other lanes 0 (acc=8) → acc_o=1 without the macro, 0 with FX_DOT_RNE_EN. For acc=24 (din=24) → acc_o=2 in both builds.
- K=2, bubbles: vld_i pattern 1,0,0,1 → same result as back-to-back. rdy_o stays 1 until the second beat, then 0 through DRAIN/OUT.
- Hold rdy_i=0 for 5 cycles in OUT → vld_o, acc_o and sat_o are constant and rdy_o=0. The first rdy_i=1 edge consumes, and the next vector then starts from accumulator 0.
- Assert clr_i after beat 1 of K=2, and separately during OUT → vld_o stays or drops to 0, and the state returns to ACC. A fresh vector yields the correct result. rstn pulse mid-vector → all outputs return to reset values.
